// File: rtl/q_row_fetch.sv
// rtl/q_row_fetch.sv - Q-table row reader: fetches N_ACT action values for a state and presents them in parallel.
// Optional Q_ROW_ARGMAX_EN adds a running sign-magnitude max (q_max/q_argmax) computed at capture.
module q_row_fetch #(
   parameter int STATE_W = 6,
   parameter int ACT_W   = 2,
   parameter int DATA_W  = 16,
   parameter int RAM_LAT = 1,
   localparam int N_ACT  = 2**ACT_W,
   localparam int AW     = STATE_W + ACT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [STATE_W-1:0]      req_state,
   output logic                    ram_en,
   output logic [AW-1:0]           ram_addr,
   input  logic [DATA_W-1:0]       ram_rdata,
   output logic                    q_valid,
   input  logic                    q_ready,
   output logic [N_ACT*DATA_W-1:0] q_row,
`ifdef Q_ROW_ARGMAX_EN
   output logic [DATA_W-1:0]       q_max,
   output logic [ACT_W-1:0]        q_argmax,
`endif
   output logic [STATE_W-1:0]      q_state
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD} state_t;

   state_t                    state_q, state_d;
   logic [ACT_W-1:0]          issue_cnt_q, issue_cnt_d;
   logic [ACT_W-1:0]          cap_cnt_q;
   logic [RAM_LAT-1:0]        vpipe_q;
   logic [AW-1:0]             addr_q;
   logic [STATE_W-1:0]        q_state_q;
   logic [N_ACT*DATA_W-1:0]   q_row_q;
   logic                      accept;
   logic                      capture;
   logic                      last_cap;

   assign accept   = req_valid && (state_q == S_IDLE);
   assign capture  = vpipe_q[RAM_LAT-1];
   assign last_cap = capture && (cap_cnt_q == ACT_W'(N_ACT-1));

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      req_ready   = 1'b0;
      ram_en      = 1'b0;
      q_valid     = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d     = S_ISSUE;
               issue_cnt_d = '0;
            end
         end
         S_ISSUE: begin
            ram_en      = 1'b1;
            issue_cnt_d = issue_cnt_q + 1'b1;
            if (issue_cnt_q == ACT_W'(N_ACT-1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (last_cap) state_d = S_HOLD;
         end
         S_HOLD: begin
            q_valid = 1'b1;
            if (q_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Address is driven live while issuing and frozen at the last issued value otherwise.
   assign ram_addr = ram_en ? {q_state_q, issue_cnt_q} : addr_q;
   assign q_row    = q_row_q;
   assign q_state  = q_state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         issue_cnt_q <= '0;
         cap_cnt_q   <= '0;
         vpipe_q     <= '0;
         addr_q      <= '0;
         q_state_q   <= '0;
         q_row_q     <= '0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         vpipe_q[0]  <= ram_en;
         for (int i = 1; i < RAM_LAT; i++) vpipe_q[i] <= vpipe_q[i-1];
         if (ram_en) addr_q <= ram_addr;
         if (accept) begin
            q_state_q <= req_state;
            cap_cnt_q <= '0;
         end else if (capture) begin
            q_row_q[cap_cnt_q*DATA_W +: DATA_W] <= ram_rdata;
            cap_cnt_q <= cap_cnt_q + 1'b1;
         end
      end
   end

`ifdef Q_ROW_ARGMAX_EN
   logic [DATA_W-1:0] max_q;
   logic [ACT_W-1:0]  argmax_q;
   logic              beats;

   // Positive beats negative; same sign compares raw magnitude; ties keep the earlier slot.
   always_comb begin
      if (ram_rdata[DATA_W-1] != max_q[DATA_W-1]) beats = ~ram_rdata[DATA_W-1];
      else beats = ram_rdata[DATA_W-2:0] > max_q[DATA_W-2:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_q    <= '0;
         argmax_q <= '0;
      end else if (accept) begin
         max_q    <= '0;
         argmax_q <= '0;
      end else if (capture && ((cap_cnt_q == '0) || beats)) begin
         max_q    <= ram_rdata;
         argmax_q <= cap_cnt_q;
      end
   end

   assign q_max    = max_q;
   assign q_argmax = argmax_q;
`endif

endmodule

// File: tb/tb_q_row_fetch.sv
// tb/tb_q_row_fetch.sv - randomized self-checking bench for q_row_fetch against a row/max reference model.
module tb_q_row_fetch #(parameter int TB_LAT = 1);

   localparam int N_ACT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_state;
   logic        ram_en;
   logic [7:0]  ram_addr;
   logic [15:0] ram_rdata;
   logic        q_valid;
   logic        q_ready;
   logic [63:0] q_row;
   logic [5:0]  q_state;
`ifdef Q_ROW_ARGMAX_EN
   logic [15:0] q_max;
   logic [1:0]  q_argmax;
`endif

   int vectors = 0;
   int errors  = 0;

   logic [15:0] mem [256];
   logic [15:0] rpipe [TB_LAT];

   always #5 clk = ~clk;

   q_row_fetch #(.RAM_LAT(TB_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_state(req_state),
      .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
      .q_valid(q_valid), .q_ready(q_ready), .q_row(q_row),
`ifdef Q_ROW_ARGMAX_EN
      .q_max(q_max), .q_argmax(q_argmax),
`endif
      .q_state(q_state)
   );

   // Behavioural RAM with TB_LAT cycles of read latency.
   always @(posedge clk) begin
      if (ram_en) rpipe[0] <= mem[ram_addr];
      for (int i = 1; i < TB_LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign ram_rdata = rpipe[TB_LAT-1];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Ordering key for the sign-magnitude rule: any positive outranks any negative.
   function automatic logic [15:0] sm_key(input logic [15:0] v);
      return {~v[15], v[14:0]};
   endfunction

   task automatic do_fetch(input logic [5:0] st, input int hold, input bit pulse);
      int          edges, issued, w, best;
      logic [63:0] exp_row;
      for (w = 0; !req_ready && w < 20; w++) begin
         @(posedge clk); #1;
      end
      chk("req_ready_pre", req_ready, 1);
      req_valid = 1'b1;
      req_state = st;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_state = 6'($urandom);
      edges  = 0;
      issued = 0;
      while (!q_valid && edges < 30) begin
         if (ram_en) begin
            chk("ram_addr", ram_addr, {st, 2'(issued)});
            issued++;
         end
         @(posedge clk); #1;
         edges++;
      end
      chk("latency", edges, N_ACT + TB_LAT);
      chk("issued", issued, N_ACT);
      best = 0;
      for (int a = 0; a < N_ACT; a++) begin
         exp_row[a*16 +: 16] = mem[{st, 2'(a)}];
         if (sm_key(mem[{st, 2'(a)}]) > sm_key(mem[{st, 2'(best)}])) best = a;
      end
      chk("q_row", q_row, exp_row);
      chk("q_state", q_state, st);
      chk("req_ready_busy", req_ready, 0);
`ifdef Q_ROW_ARGMAX_EN
      chk("q_max", q_max, mem[{st, 2'(best)}]);
      chk("q_argmax", q_argmax, best);
`endif
      for (int h = 0; h < hold; h++) begin
         req_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
         chk("hold_valid", q_valid, 1);
         chk("hold_row", q_row, exp_row);
         chk("hold_state", q_state, st);
         chk("hold_ready", req_ready, 0);
         chk("hold_ram_en", ram_en, 0);
      end
      req_valid = 1'b0;
      q_ready   = 1'b1;
      @(posedge clk); #1;
      q_ready = 1'b0;
      chk("post_ready", req_ready, 1);
      chk("post_valid", q_valid, 0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_state = '0;
      q_ready   = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      for (int a = 0; a < N_ACT; a++) mem[{6'd5, 2'(a)}] = 16'((a + 1) * 16);
      mem[{6'd10, 2'd0}] = 16'h8005; mem[{6'd10, 2'd1}] = 16'h0003;
      mem[{6'd10, 2'd2}] = 16'h0003; mem[{6'd10, 2'd3}] = 16'h8000;
      mem[{6'd11, 2'd0}] = 16'h8001; mem[{6'd11, 2'd1}] = 16'h8007;
      mem[{6'd11, 2'd2}] = 16'h8002; mem[{6'd11, 2'd3}] = 16'h8007;
      for (int i = 0; i < TB_LAT; i++) rpipe[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_q_valid", q_valid, 0);
      chk("rst_q_row", q_row, 0);
      chk("rst_q_state", q_state, 0);
`ifdef Q_ROW_ARGMAX_EN
      chk("rst_q_max", q_max, 0);
      chk("rst_q_argmax", q_argmax, 0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      do_fetch(6'd5, 10, 1'b1);
      chk("row5_const", q_row, 64'h0040_0030_0020_0010);
      do_fetch(6'd1, 0, 1'b0);
      do_fetch(6'd2, 0, 1'b0);

      // Asynchronous reset while the third action address is on the bus.
      req_valid = 1'b1;
      req_state = 6'd7;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_addr", ram_addr, {6'd7, 2'd2});
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", q_valid, 0);
      chk("mid_rst_ram_en", ram_en, 0);
      chk("mid_rst_ready", req_ready, 1);
      chk("mid_rst_row", q_row, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      do_fetch(6'd3, 2, 1'b0);

      do_fetch(6'd10, 1, 1'b0);
`ifdef Q_ROW_ARGMAX_EN
      chk("max10_const", {q_max, 14'd0, q_argmax}, {16'h0003, 14'd0, 2'd1});
`endif
      do_fetch(6'd11, 1, 1'b0);
`ifdef Q_ROW_ARGMAX_EN
      chk("max11_const", {q_max, 14'd0, q_argmax}, {16'h8007, 14'd0, 2'd1});
`endif

      for (int n = 0; n < 25; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         do_fetch(6'($urandom), $urandom_range(0, 4), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
